// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - state encoding, opcode map, ALU codes and decode helpers for the multicycle control unit
package cu_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  typedef enum logic [3:0] {
    CL_ALU, CL_CMP, CL_PUT, CL_JUMP, CL_STACK, CL_SWAP, CL_MEM, CL_HALT, CL_ILLEGAL
  } op_class_e;

  // Opcodes held 32 bits wide so they compare cleanly against any OPCODE_W
  localparam logic [31:0] OP_PUT  = 32'd0;
  localparam logic [31:0] OP_ADD  = 32'd1;
  localparam logic [31:0] OP_SUB  = 32'd2;
  localparam logic [31:0] OP_LORR = 32'd3;
  localparam logic [31:0] OP_LAND = 32'd4;
  localparam logic [31:0] OP_SHFL = 32'd5;
  localparam logic [31:0] OP_CEQU = 32'd6;
  localparam logic [31:0] OP_CLES = 32'd7;
  localparam logic [31:0] OP_CGRE = 32'd8;
  localparam logic [31:0] OP_JIMM = 32'd9;
  localparam logic [31:0] OP_JACC = 32'd10;
  localparam logic [31:0] OP_JCMP = 32'd11;
  localparam logic [31:0] OP_JFNC = 32'd12;
  localparam logic [31:0] OP_JRET = 32'd13;
  localparam logic [31:0] OP_SPUT = 32'd14;
  localparam logic [31:0] OP_SPOP = 32'd15;
  localparam logic [31:0] OP_SWAP = 32'd16;
  localparam logic [31:0] OP_LOAD = 32'd17;
  localparam logic [31:0] OP_STOR = 32'd18;
  localparam logic [31:0] OP_HALT = 32'd31;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SHL = 3'd4;
  localparam logic [2:0] ALU_EQ  = 3'd5;
  localparam logic [2:0] ALU_LT  = 3'd6;
  localparam logic [2:0] ALU_GT  = 3'd7;

  localparam logic [1:0] PC_SRC_INC   = 2'd0;
  localparam logic [1:0] PC_SRC_IMM   = 2'd1;
  localparam logic [1:0] PC_SRC_ACC   = 2'd2;
  localparam logic [1:0] PC_SRC_RA    = 2'd3;
  localparam logic [1:0] ACC_SRC_SWAP = 2'd2;
  localparam logic [1:0] ACC_SRC_IMM  = 2'd3;
  localparam logic       SP_SRC_PUSH  = 1'b0;
  localparam logic       SP_SRC_POP   = 1'b1;
  localparam logic       RA_SRC_PC    = 1'b0;
  localparam logic       RA_SRC_TRAP  = 1'b1;

  // HALT is always the all-ones code of the configured opcode width
  function automatic op_class_e op_class(input logic [31:0] op, input int op_w);
    logic [31:0] halt_code;
    op_class_e   cls;
    halt_code = (op_w >= 32) ? '1 : ((32'd1 << op_w) - 32'd1);
    case (op)
      OP_ADD, OP_SUB, OP_LORR, OP_LAND, OP_SHFL:       cls = CL_ALU;
      OP_CEQU, OP_CLES, OP_CGRE:                       cls = CL_CMP;
      OP_PUT:                                          cls = CL_PUT;
      OP_JIMM, OP_JACC, OP_JCMP, OP_JFNC, OP_JRET:     cls = CL_JUMP;
      OP_SPUT, OP_SPOP:                                cls = CL_STACK;
      OP_SWAP:                                         cls = CL_SWAP;
      OP_LOAD, OP_STOR:                                cls = CL_MEM;
      default:                                         cls = CL_ILLEGAL;
    endcase
    if (op == halt_code) cls = CL_HALT;
    return cls;
  endfunction

  function automatic logic [2:0] alu_code(input logic [31:0] op);
    logic [2:0] code;
    case (op)
      OP_SUB:  code = ALU_SUB;
      OP_LORR: code = ALU_OR;
      OP_LAND: code = ALU_AND;
      OP_SHFL: code = ALU_SHL;
      OP_CEQU: code = ALU_EQ;
      OP_CLES: code = ALU_LT;
      OP_CGRE: code = ALU_GT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cu_stall_timer.sv
// rtl/cu_stall_timer.sv - counts consecutive memory stall cycles and raises a sticky mem_err on timeout
module cu_stall_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_active,
  input  logic mem_ready,
  output logic timeout,
  output logic mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt;
  logic             stalled;

  assign stalled = wait_active && !mem_ready;
  // Fires on the MEM_TIMEOUT-th consecutive stall cycle
  assign timeout = EN && stalled && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      if (!stalled || timeout || !EN) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
      if (timeout) mem_err <= 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the Mary/Shelley machine
// CU_ILLEGAL_TRAP_EN: unassigned opcodes trap instead of retiring as a NOP.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 5,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flagbit,
  input  logic                mem_ready,
  input  logic                cmp_true,
  output logic [2:0]          state,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemSrc,
  output logic                RegWrite,
  output logic                MaryWrite,
  output logic                ShelleyWrite,
  output logic                CompWrite,
  output logic                RAWrite,
  output logic                PCWrite,
  output logic                SPWrite,
  output logic [1:0]          MarySrc,
  output logic [1:0]          ShelleySrc,
  output logic [1:0]          PCSrc,
  output logic                RASrc,
  output logic                SPSrc,
  output logic                RegDst,
  output logic                RegData,
  output logic                SrcA,
  output logic                SrcB,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                instr_done,
  output logic                mem_err,
  output logic                illegal_op
);
  import cu_pkg::*;

  logic [2:0]  state_q, state_d;
  logic [31:0] op_u;
  op_class_e   cls;
  logic        mem_rd_op;
  logic        retire;
  logic        timeout;
  logic        err_q;

  assign op_u      = 32'(opcode);
  assign cls       = op_class(op_u, OPCODE_W);
  assign mem_rd_op = (op_u == OP_LOAD) || (op_u == OP_SPOP);

  cu_stall_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_stall_timer (
    .clk        (clk),
    .reset      (reset),
    .wait_active((state_q == ST_FETCH) || (state_q == ST_MEM)),
    .mem_ready  (mem_ready),
    .timeout    (timeout),
    .mem_err    (err_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Nothing escapes during the reset cycle, including the sticky flags
  assign state   = reset ? ST_FETCH : state_q;
  assign mem_err = err_q & ~reset;

`ifdef CU_ILLEGAL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk) begin
    if (reset)                  ill_q <= 1'b0;
    else if (state_d == ST_TRAP) ill_q <= 1'b1;
  end
  assign illegal_op = ill_q & ~reset;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    IRWrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemSrc       = 1'b0;
    RegWrite     = 1'b0;
    MaryWrite    = 1'b0;
    ShelleyWrite = 1'b0;
    CompWrite    = 1'b0;
    RAWrite      = 1'b0;
    PCWrite      = 1'b0;
    SPWrite      = 1'b0;
    MarySrc      = 2'd0;
    ShelleySrc   = 2'd0;
    PCSrc        = PC_SRC_INC;
    RASrc        = 1'b0;
    SPSrc        = 1'b0;
    RegDst       = 1'b0;
    RegData      = 1'b0;
    SrcA         = 1'b0;
    SrcB         = 1'b0;
    ALUOP        = '0;
    instr_done   = 1'b0;
    retire       = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = ST_DECODE;
          end else if (timeout) begin
            state_d = ST_HALTED;
          end
        end
        ST_DECODE: begin
          case (cls)
            CL_MEM:     state_d = ST_MEM;
            CL_HALT:    state_d = ST_HALTED;
`ifdef CU_ILLEGAL_TRAP_EN
            CL_ILLEGAL: state_d = ST_TRAP;
`endif
            default:    state_d = ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          retire = 1'b1;
          case (cls)
            CL_ALU: begin
              SrcA    = flagbit;
              SrcB    = 1'b1;
              ALUOP   = ALUOP_W'(alu_code(op_u));
              retire  = 1'b0;
              state_d = ST_WB;
            end
            CL_CMP: begin
              CompWrite = 1'b1;
              ALUOP     = ALUOP_W'(alu_code(op_u));
            end
            CL_PUT: begin
              if (flagbit) begin
                ShelleyWrite = 1'b1;
                ShelleySrc   = ACC_SRC_IMM;
              end else begin
                MaryWrite = 1'b1;
                MarySrc   = ACC_SRC_IMM;
              end
            end
            CL_JUMP: begin
              PCWrite = 1'b1;
              PCSrc   = PC_SRC_IMM;
              if (op_u == OP_JACC)      PCSrc = PC_SRC_ACC;
              else if (op_u == OP_JRET) PCSrc = PC_SRC_RA;
              else if (op_u == OP_JCMP) PCWrite = cmp_true;
              else if (op_u == OP_JFNC) begin
                RAWrite = 1'b1;
                RASrc   = RA_SRC_PC;
              end
            end
            CL_STACK: begin
              SPWrite = 1'b1;
              SPSrc   = (op_u == OP_SPOP) ? SP_SRC_POP : SP_SRC_PUSH;
              retire  = 1'b0;
              state_d = ST_MEM;
            end
            CL_SWAP: begin
              MaryWrite    = 1'b1;
              ShelleyWrite = 1'b1;
              MarySrc      = ACC_SRC_SWAP;
              ShelleySrc   = ACC_SRC_SWAP;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          MemSrc   = 1'b1;
          MemRead  = mem_rd_op;
          MemWrite = !mem_rd_op;
          if (mem_ready) begin
            if (mem_rd_op) state_d = ST_WB;
            else           retire  = 1'b1;
          end else if (timeout) begin
            state_d = ST_HALTED;
          end
        end
        ST_WB: begin
          RegWrite = 1'b1;
          RegData  = mem_rd_op;
          if (flagbit) ShelleyWrite = 1'b1;
          else         MaryWrite    = 1'b1;
          retire = 1'b1;
        end
        ST_TRAP: begin
          RAWrite = 1'b1;
          RASrc   = RA_SRC_TRAP;
          PCWrite = 1'b1;
          PCSrc   = PC_SRC_IMM;
          state_d = ST_FETCH;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_FETCH;
      endcase
      if (retire) begin
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multicycle control unit
module tb_multicycle_control_unit;

  localparam logic [4:0] O_PUT = 5'd0, O_ADD = 5'd1, O_SUB = 5'd2, O_LORR = 5'd3, O_LAND = 5'd4;
  localparam logic [4:0] O_SHFL = 5'd5, O_CEQU = 5'd6, O_CLES = 5'd7, O_CGRE = 5'd8;
  localparam logic [4:0] O_JIMM = 5'd9, O_JACC = 5'd10, O_JCMP = 5'd11, O_JFNC = 5'd12, O_JRET = 5'd13;
  localparam logic [4:0] O_SPUT = 5'd14, O_SPOP = 5'd15, O_SWAP = 5'd16, O_LOAD = 5'd17, O_STOR = 5'd18;
  localparam logic [4:0] O_BAD = 5'd30, O_HALT = 5'd31;

  typedef struct packed {
    logic ir, mrd, mwr, msrc, regw, maryw, shw, cmpw, raw, pcw, spw;
    logic [1:0] marys, shs, pcs;
    logic ras, sps, regdst, regdata, srca, srcb;
    logic [2:0] aluop;
    logic done, merr, ill;
    logic [2:0] st;
  } obs_t;

  typedef struct packed {
    logic [4:0] op;
    logic flag, rdy, cmp, rst;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1, flagbit = 1'b0, mem_ready = 1'b0, cmp_true = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic [2:0] state, ALUOP;
  logic IRWrite, MemRead, MemWrite, MemSrc, RegWrite, MaryWrite, ShelleyWrite, CompWrite;
  logic RAWrite, PCWrite, SPWrite, RASrc, SPSrc, RegDst, RegData, SrcA, SrcB;
  logic instr_done, mem_err, illegal_op;
  logic [1:0] MarySrc, ShelleySrc, PCSrc;
  obs_t obs;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPCODE_W(5), .ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .flagbit(flagbit), .mem_ready(mem_ready),
    .cmp_true(cmp_true), .state(state), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemSrc(MemSrc), .RegWrite(RegWrite), .MaryWrite(MaryWrite),
    .ShelleyWrite(ShelleyWrite), .CompWrite(CompWrite), .RAWrite(RAWrite), .PCWrite(PCWrite),
    .SPWrite(SPWrite), .MarySrc(MarySrc), .ShelleySrc(ShelleySrc), .PCSrc(PCSrc),
    .RASrc(RASrc), .SPSrc(SPSrc), .RegDst(RegDst), .RegData(RegData), .SrcA(SrcA),
    .SrcB(SrcB), .ALUOP(ALUOP), .instr_done(instr_done), .mem_err(mem_err),
    .illegal_op(illegal_op)
  );

  assign obs = {IRWrite, MemRead, MemWrite, MemSrc, RegWrite, MaryWrite, ShelleyWrite,
                CompWrite, RAWrite, PCWrite, SPWrite, MarySrc, ShelleySrc, PCSrc, RASrc,
                SPSrc, RegDst, RegData, SrcA, SrcB, ALUOP, instr_done, mem_err,
                illegal_op, state};

  function automatic obs_t st_e(input logic [2:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic obs_t fetch_e(input logic rdy);
    obs_t e;
    e = st_e(3'd0);
    e.mrd = 1'b1;
    e.ir  = rdy;
    e.pcw = rdy;
    return e;
  endfunction

  task automatic add_cycle(input logic [4:0] op, input logic flag, rdy, cmp, rst, input obs_t e);
    stim_q.push_back({op, flag, rdy, cmp, rst});
    exp_q.push_back(e);
  endtask

  task automatic drive_next();
    stim_t s;
    s = stim_q.pop_front();
    opcode = s.op; flagbit = s.flag; mem_ready = s.rdy; cmp_true = s.cmp; reset = s.rst;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    obs_t e;
    add_cycle(O_ADD, 1'b1, 1'b1, 1'b1, 1'b1, st_e(3'd0));
    add_cycle(O_STOR, 1'b0, 1'b1, 1'b0, 1'b1, st_e(3'd0));
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL reset cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  task automatic test_alu();
    obs_t e;
    logic [4:0] ops [5];
    ops = '{O_ADD, O_SUB, O_LORR, O_LAND, O_SHFL};
    for (int i = 0; i < 5; i++) begin
      logic f;
      f = (i % 2 == 0);
      add_cycle(ops[i], f, 1'b1, 1'b0, 1'b0, fetch_e(1'b1));
      add_cycle(ops[i], f, 1'b1, 1'b0, 1'b0, st_e(3'd1));
      e = st_e(3'd2); e.srca = f; e.srcb = 1'b1; e.aluop = 3'(i);
      add_cycle(ops[i], f, 1'b1, 1'b0, 1'b0, e);
      e = st_e(3'd4); e.regw = 1'b1; e.done = 1'b1;
      if (f) e.shw = 1'b1; else e.maryw = 1'b1;
      add_cycle(ops[i], f, 1'b1, 1'b0, 1'b0, e);
    end
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL alu cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  task automatic test_load_store();
    obs_t e;
    add_cycle(O_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, fetch_e(1'b1));
    add_cycle(O_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, st_e(3'd1));
    e = st_e(3'd3); e.msrc = 1'b1; e.mrd = 1'b1;
    for (int i = 0; i < 3; i++) add_cycle(O_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, e);
    add_cycle(O_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, e);
    e = st_e(3'd4); e.regw = 1'b1; e.regdata = 1'b1; e.maryw = 1'b1; e.done = 1'b1;
    add_cycle(O_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, e);
    add_cycle(O_STOR, 1'b1, 1'b1, 1'b0, 1'b0, fetch_e(1'b1));
    add_cycle(O_STOR, 1'b1, 1'b0, 1'b0, 1'b0, st_e(3'd1));
    e = st_e(3'd3); e.msrc = 1'b1; e.mwr = 1'b1; e.done = 1'b1;
    add_cycle(O_STOR, 1'b1, 1'b1, 1'b0, 1'b0, e);
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL load_store cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  task automatic push_jump(input logic [4:0] op, input logic cmp, input logic [1:0] pcs,
                           input logic pcw, input logic raw);
    obs_t e;
    add_cycle(op, 1'b0, 1'b1, cmp, 1'b0, fetch_e(1'b1));
    add_cycle(op, 1'b0, 1'b1, cmp, 1'b0, st_e(3'd1));
    e = st_e(3'd2); e.pcs = pcs; e.pcw = pcw; e.raw = raw; e.done = 1'b1;
    add_cycle(op, 1'b0, 1'b1, cmp, 1'b0, e);
  endtask

  task automatic test_jumps();
    obs_t e;
    push_jump(O_JCMP, 1'b0, 2'd1, 1'b0, 1'b0);
    push_jump(O_JCMP, 1'b1, 2'd1, 1'b1, 1'b0);
    push_jump(O_JIMM, 1'b0, 2'd1, 1'b1, 1'b0);
    push_jump(O_JACC, 1'b1, 2'd2, 1'b1, 1'b0);
    push_jump(O_JFNC, 1'b0, 2'd1, 1'b1, 1'b1);
    push_jump(O_JRET, 1'b0, 2'd3, 1'b1, 1'b0);
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL jumps cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  task automatic push_exec1(input logic [4:0] op, input logic flag, input obs_t ex);
    add_cycle(op, flag, 1'b1, 1'b0, 1'b0, fetch_e(1'b1));
    add_cycle(op, flag, 1'b1, 1'b0, 1'b0, st_e(3'd1));
    add_cycle(op, flag, 1'b1, 1'b0, 1'b0, ex);
  endtask

  task automatic test_misc();
    obs_t e;
    logic [4:0] cops [3];
    cops = '{O_CEQU, O_CLES, O_CGRE};
    for (int i = 0; i < 3; i++) begin
      e = st_e(3'd2); e.cmpw = 1'b1; e.aluop = 3'(5 + i); e.done = 1'b1;
      push_exec1(cops[i], 1'b0, e);
    end
    e = st_e(3'd2); e.shw = 1'b1; e.shs = 2'd3; e.done = 1'b1;
    push_exec1(O_PUT, 1'b1, e);
    e = st_e(3'd2); e.maryw = 1'b1; e.marys = 2'd3; e.done = 1'b1;
    push_exec1(O_PUT, 1'b0, e);
    e = st_e(3'd2); e.maryw = 1'b1; e.shw = 1'b1; e.marys = 2'd2; e.shs = 2'd2; e.done = 1'b1;
    push_exec1(O_SWAP, 1'b0, e);
    e = st_e(3'd2); e.spw = 1'b1;
    push_exec1(O_SPUT, 1'b0, e);
    e = st_e(3'd3); e.msrc = 1'b1; e.mwr = 1'b1; e.done = 1'b1;
    add_cycle(O_SPUT, 1'b0, 1'b1, 1'b0, 1'b0, e);
    e = st_e(3'd2); e.spw = 1'b1; e.sps = 1'b1;
    push_exec1(O_SPOP, 1'b1, e);
    e = st_e(3'd3); e.msrc = 1'b1; e.mrd = 1'b1;
    add_cycle(O_SPOP, 1'b1, 1'b1, 1'b0, 1'b0, e);
    e = st_e(3'd4); e.regw = 1'b1; e.regdata = 1'b1; e.shw = 1'b1; e.done = 1'b1;
    add_cycle(O_SPOP, 1'b1, 1'b1, 1'b0, 1'b0, e);
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL misc cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  task automatic test_illegal_halt();
    obs_t e;
    add_cycle(O_BAD, 1'b0, 1'b1, 1'b0, 1'b0, fetch_e(1'b1));
    add_cycle(O_BAD, 1'b0, 1'b1, 1'b0, 1'b0, st_e(3'd1));
`ifdef CU_ILLEGAL_TRAP_EN
    e = st_e(3'd5); e.raw = 1'b1; e.ras = 1'b1; e.pcw = 1'b1; e.pcs = 2'd1; e.ill = 1'b1;
    add_cycle(O_BAD, 1'b0, 1'b1, 1'b0, 1'b0, e);
    e = fetch_e(1'b0); e.ill = 1'b1;
    add_cycle(O_BAD, 1'b0, 1'b0, 1'b0, 1'b0, e);
    add_cycle(O_BAD, 1'b0, 1'b0, 1'b0, 1'b1, st_e(3'd0));
`else
    e = st_e(3'd2); e.done = 1'b1;
    add_cycle(O_BAD, 1'b0, 1'b1, 1'b0, 1'b0, e);
`endif
    add_cycle(O_HALT, 1'b0, 1'b1, 1'b0, 1'b0, fetch_e(1'b1));
    add_cycle(O_HALT, 1'b0, 1'b1, 1'b0, 1'b0, st_e(3'd1));
    for (int i = 0; i < 3; i++) add_cycle(O_HALT, 1'b0, 1'b1, 1'b0, 1'b0, st_e(3'd6));
    add_cycle(O_HALT, 1'b0, 1'b1, 1'b0, 1'b1, st_e(3'd0));
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL illegal_halt cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    add_cycle(O_STOR, 1'b0, 1'b1, 1'b0, 1'b0, fetch_e(1'b1));
    add_cycle(O_STOR, 1'b0, 1'b0, 1'b0, 1'b0, st_e(3'd1));
    e = st_e(3'd3); e.msrc = 1'b1; e.mwr = 1'b1;
    add_cycle(O_STOR, 1'b0, 1'b0, 1'b0, 1'b0, e);
    add_cycle(O_STOR, 1'b0, 1'b1, 1'b0, 1'b1, st_e(3'd0));
    add_cycle(O_STOR, 1'b0, 1'b0, 1'b0, 1'b0, fetch_e(1'b0));
    add_cycle(O_STOR, 1'b0, 1'b0, 1'b0, 1'b1, st_e(3'd0));
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL reset_mid cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  task automatic test_timeout();
    obs_t e;
    for (int i = 0; i < 14; i++) add_cycle(O_JIMM, 1'b0, 1'b0, 1'b0, 1'b0, fetch_e(1'b0));
    push_jump(O_JIMM, 1'b0, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) add_cycle(O_JIMM, 1'b0, 1'b0, 1'b0, 1'b0, fetch_e(1'b0));
    e = st_e(3'd6); e.merr = 1'b1;
    for (int i = 0; i < 3; i++) add_cycle(O_JIMM, 1'b0, 1'b1, 1'b0, 1'b0, e);
    add_cycle(O_JIMM, 1'b0, 1'b1, 1'b0, 1'b1, st_e(3'd0));
    add_cycle(O_JIMM, 1'b0, 1'b0, 1'b0, 1'b0, fetch_e(1'b0));
    while (stim_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL timeout cycle %0d: got %h expected %h", cyc, obs, e); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_jumps();
    test_misc();
    test_illegal_halt();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
